// File: rtl/ysyx_25060170_defs.sv
// Shared definitions for the write-back unit slice.
// Contents: default data width and register count, register-index width,
// reset constants, the arbiter grant encoding and a small x0 helper.
package ysyx_25060170_defs;

  localparam int XLEN_DEF   = 32;
  localparam int NR_GPR_DEF = 32;
  localparam int REG_W      = 5;
  // Scoreboard storage always spans every encodable index so a 5-bit
  // lookup can never go out of range; bits at or above NR_GPR stay zero.
  localparam int REG_CNT    = 1 << REG_W;

  localparam logic             RST_WE     = 1'b0;
  localparam logic [REG_W-1:0] RST_WRITER = 5'd0;

  // Which source owns the register-file write port on the next edge.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_LSU  = 2'd1,
    GNT_EXU  = 2'd2
  } gnt_e;

  // True for the hardwired-zero register.
  function automatic logic is_x0(input logic [REG_W-1:0] idx);
    return (idx == {REG_W{1'b0}});
  endfunction

endpackage

// File: rtl/ysyx_25060170_scoreboard.sv
// Pending-load scoreboard: one busy bit per architectural register.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   set_en, set_idx    a load has been issued to set_idx
//   clr_en, clr_idx    load data for clr_idx has been written back
//   query_idx          combinational lookup index
//   query_busy         busy[query_idx]
//   busy_vec           full busy vector (used by the write-back arbiter)
// When set and clear hit the same register on one edge, set wins: a newer
// load to that register is now outstanding.
module ysyx_25060170_scoreboard
  import ysyx_25060170_defs::*;
#(
  parameter int NR_GPR = NR_GPR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_en,
  input  logic [REG_W-1:0]   set_idx,
  input  logic               clr_en,
  input  logic [REG_W-1:0]   clr_idx,
  input  logic [REG_W-1:0]   query_idx,
  output logic               query_busy,
  output logic [REG_CNT-1:0] busy_vec
);

  logic [REG_CNT-1:0] busy_r;
  logic [REG_CNT-1:0] set_vec_s;
  logic [REG_CNT-1:0] clr_vec_s;

  // Decode set/clear requests into one-hot masks; x0 and indices beyond
  // NR_GPR are never set, which keeps those bits permanently zero.
  always_comb begin
    set_vec_s = {REG_CNT{1'b0}};
    clr_vec_s = {REG_CNT{1'b0}};
    for (int i = 0; i < REG_CNT; i++) begin
      if (set_en && (set_idx == REG_W'(i)) && (i != 0) && (i < NR_GPR)) begin
        set_vec_s[i] = 1'b1;
      end else begin
        set_vec_s[i] = 1'b0;
      end
      if (clr_en && (clr_idx == REG_W'(i))) begin
        clr_vec_s[i] = 1'b1;
      end else begin
        clr_vec_s[i] = 1'b0;
      end
    end
  end

  // Busy-bit state: clear first, then OR in sets so set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= {REG_CNT{1'b0}};
    end else begin
      busy_r <= (busy_r & ~clr_vec_s) | set_vec_s;
    end
  end

  assign busy_vec   = busy_r;
  assign query_busy = busy_r[query_idx];

endmodule

// File: rtl/ysyx_25060170_wbu.sv
// Write-back unit: arbitrates EXU results and LSU load data onto the
// register-file write port and tracks pending loads for decode.
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   exu_valid/exu_ready/exu_rd/exu_data EXU result handshake
//   lsu_valid/lsu_ready/lsu_rd/lsu_data load data handshake (always ready)
//   ld_issue, ld_rd                    load issued, marks ld_rd pending
//   query_rs, query_busy               decode's pending-load lookup
//   fwd_hit, fwd_data                  bypass of the in-flight GPR write
//   GPR_we, GPR_writer, GPR_wd         registered register-file write port
// Optional feature macro: YSYX_25060170_WBU_FWD_EN enables the bypass
// outputs; without it fwd_hit and fwd_data are tied to zero.
module ysyx_25060170_wbu
  import ysyx_25060170_defs::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NR_GPR = NR_GPR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exu_valid,
  output logic             exu_ready,
  input  logic [REG_W-1:0] exu_rd,
  input  logic [XLEN-1:0]  exu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [REG_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]  lsu_data,
  input  logic             ld_issue,
  input  logic [REG_W-1:0] ld_rd,
  input  logic [REG_W-1:0] query_rs,
  output logic             query_busy,
  output logic             fwd_hit,
  output logic [XLEN-1:0]  fwd_data,
  output logic             GPR_we,
  output logic [REG_W-1:0] GPR_writer,
  output logic [XLEN-1:0]  GPR_wd
);

  logic [REG_CNT-1:0] busy_vec_s;
  gnt_e               gnt_s;
  logic [REG_W-1:0]   sel_rd_s;
  logic [XLEN-1:0]    sel_data_s;
  logic               gpr_we_r;
  logic [REG_W-1:0]   gpr_writer_r;
  logic [XLEN-1:0]    gpr_wd_r;

  ysyx_25060170_scoreboard #(
    .NR_GPR (NR_GPR)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (ld_issue),
    .set_idx    (ld_rd),
    .clr_en     (lsu_valid),
    .clr_idx    (lsu_rd),
    .query_idx  (query_rs),
    .query_busy (query_busy),
    .busy_vec   (busy_vec_s)
  );

  // The load is always older, so the LSU never waits. The EXU also waits
  // while its destination has a load outstanding, otherwise that load
  // would later overwrite the newer EXU value.
  assign lsu_ready = 1'b1;
  assign exu_ready = !lsu_valid && !busy_vec_s[exu_rd];

  // Fixed-priority grant and selection of the winning source.
  always_comb begin
    gnt_s      = GNT_NONE;
    sel_rd_s   = {REG_W{1'b0}};
    sel_data_s = {XLEN{1'b0}};
    if (lsu_valid) begin
      gnt_s = GNT_LSU;
    end else if (exu_valid && exu_ready) begin
      gnt_s = GNT_EXU;
    end else begin
      gnt_s = GNT_NONE;
    end
    case (gnt_s)
      GNT_LSU: begin
        sel_rd_s   = lsu_rd;
        sel_data_s = lsu_data;
      end
      GNT_EXU: begin
        sel_rd_s   = exu_rd;
        sel_data_s = exu_data;
      end
      default: begin
        sel_rd_s   = {REG_W{1'b0}};
        sel_data_s = {XLEN{1'b0}};
      end
    endcase
  end

  // Register-file write port. A transfer to x0 is consumed but does not
  // raise the write enable; idle cycles keep the last address and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_we_r     <= RST_WE;
      gpr_writer_r <= RST_WRITER;
      gpr_wd_r     <= {XLEN{1'b0}};
    end else begin
      case (gnt_s)
        GNT_LSU, GNT_EXU: begin
          gpr_we_r     <= !is_x0(sel_rd_s);
          gpr_writer_r <= sel_rd_s;
          gpr_wd_r     <= sel_data_s;
        end
        default: begin
          gpr_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign GPR_we     = gpr_we_r;
  assign GPR_writer = gpr_writer_r;
  assign GPR_wd     = gpr_wd_r;

`ifdef YSYX_25060170_WBU_FWD_EN
  // The register file commits one edge after GPR_we rises; expose that
  // pending value so decode can bypass it instead of stalling.
  assign fwd_hit  = gpr_we_r && (gpr_writer_r == query_rs) && !is_x0(query_rs);
  assign fwd_data = gpr_wd_r;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = {XLEN{1'b0}};
`endif

endmodule

// File: tb/tb_ysyx_25060170_wbu.sv
// Directed bench for ysyx_25060170_wbu: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences (arbitration, load/EXU
// ordering, set-wins scoreboard, forwarding, reset mid-transfer).
module tb_ysyx_25060170_wbu;

  logic        clk;
  logic        rst;
  logic        exu_valid;
  logic        exu_ready;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic [4:0]  query_rs;
  logic        query_busy;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        GPR_we;
  logic [4:0]  GPR_writer;
  logic [31:0] GPR_wd;

  int checks;
  int failures;

  // Register-file model fed by the DUT's write port.
  logic [31:0] rf [32];

  ysyx_25060170_wbu #(
    .XLEN   (32),
    .NR_GPR (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .exu_valid  (exu_valid),
    .exu_ready  (exu_ready),
    .exu_rd     (exu_rd),
    .exu_data   (exu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .ld_issue   (ld_issue),
    .ld_rd      (ld_rd),
    .query_rs   (query_rs),
    .query_busy (query_busy),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
    .GPR_we     (GPR_we),
    .GPR_writer (GPR_writer),
    .GPR_wd     (GPR_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: commits on the edge after GPR_we is seen high.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (GPR_we && (GPR_writer != 5'd0)) begin
      rf[GPR_writer] <= GPR_wd;
    end
  end

  typedef struct {
    logic        ev;
    logic [4:0]  erd;
    logic [31:0] ed;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic [4:0]  qrs;
    logic        x_erdy;
    logic        x_qb;
    logic        x_we;
    logic        chk_w;
    logic [4:0]  x_wr;
    logic [31:0] x_wd;
    logic        chk_rf;
    logic [4:0]  rf_i;
    logic [31:0] rf_v;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    exu_valid = 1'b0; exu_rd = 5'd0; exu_data = 32'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
    ld_issue  = 1'b0; ld_rd  = 5'd0;
  endtask

  task automatic chk_port(input string nm, input logic we, input logic [4:0] wr, input logic [31:0] wd);
    chk({nm, "_we"}, {31'd0, GPR_we}, {31'd0, we});
    chk({nm, "_writer"}, {27'd0, GPR_writer}, {27'd0, wr});
    chk({nm, "_wd"}, GPR_wd, wd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    query_rs = 5'd0;
    idle();

    //       ev    erd    ed             lv    lrd    ld             qrs     erdy  qb    we    chk_w wr     wd             chk_rf rf_i   rf_v
    vecs[0] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd5,  1'b1, 1'b0, 1'b0, 1'b1, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0};
    vecs[1] = '{1'b1, 5'd5,  32'h1234,     1'b0, 5'd0, 32'h0,        5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  32'h1234,      1'b0, 5'd0,  32'h0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd5,  1'b1, 1'b0, 1'b0, 1'b1, 5'd5,  32'h1234,      1'b1, 5'd5,  32'h1234};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6, 32'hCAFEF00D, 5'd6,  1'b0, 1'b0, 1'b1, 1'b1, 5'd6,  32'hCAFEF00D,  1'b0, 5'd0,  32'h0};
    vecs[4] = '{1'b1, 5'd0,  32'h55,       1'b0, 5'd0, 32'h0,        5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd6,  32'hCAFEF00D};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h66,       5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0};
    vecs[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,        5'd31, 1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF,  1'b0, 5'd0,  32'h0};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd31, 1'b1, 1'b0, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFF,  1'b1, 5'd31, 32'hFFFFFFFF};

    // Reset state
    tick();
    tick();
    chk_port("reset", 1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    for (int r = 0; r < 32; r++) begin
      query_rs = r[4:0];
      #1;
      chk($sformatf("reset_busy_x%0d", r), {31'd0, query_busy}, 32'd0);
    end
    chk("lsu_ready", {31'd0, lsu_ready}, 32'd1);

    // Table-driven single-cycle vectors
    for (int i = 0; i < 8; i++) begin
      exu_valid = vecs[i].ev; exu_rd = vecs[i].erd; exu_data = vecs[i].ed;
      lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ld;
      query_rs  = vecs[i].qrs;
      #1;
      chk($sformatf("vec%0d_exu_ready", i), {31'd0, exu_ready}, {31'd0, vecs[i].x_erdy});
      chk($sformatf("vec%0d_query_busy", i), {31'd0, query_busy}, {31'd0, vecs[i].x_qb});
      tick();
      chk($sformatf("vec%0d_we", i), {31'd0, GPR_we}, {31'd0, vecs[i].x_we});
      if (vecs[i].chk_w) begin
        chk($sformatf("vec%0d_writer", i), {27'd0, GPR_writer}, {27'd0, vecs[i].x_wr});
        chk($sformatf("vec%0d_wd", i), GPR_wd, vecs[i].x_wd);
      end
      if (vecs[i].chk_rf) begin
        chk($sformatf("vec%0d_rf_x%0d", i, vecs[i].rf_i), rf[vecs[i].rf_i], vecs[i].rf_v);
      end
    end
    idle();

    // EXU x3 and LSU x4 together: LSU first, EXU one cycle later
    exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'h33;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hDEADBEEF;
    #1;
    chk("arb_exu_stall", {31'd0, exu_ready}, 32'd0);
    tick();
    chk_port("arb_lsu_first", 1'b1, 5'd4, 32'hDEADBEEF);
    lsu_valid = 1'b0;
    #1;
    chk("arb_exu_go", {31'd0, exu_ready}, 32'd1);
    tick();
    chk_port("arb_exu_second", 1'b1, 5'd3, 32'h33);
    idle();

    // Load to x7 outstanding blocks EXU x7 until the load returns
    ld_issue = 1'b1; ld_rd = 5'd7;
    tick();
    ld_issue = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h77;
    query_rs = 5'd7;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("waw_busy_c%0d", c), {31'd0, query_busy}, 32'd1);
      chk($sformatf("waw_stall_c%0d", c), {31'd0, exu_ready}, 32'd0);
      tick();
      chk($sformatf("waw_no_we_c%0d", c), {31'd0, GPR_we}, 32'd0);
    end
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h70;
    #1;
    chk("waw_stall_lsu", {31'd0, exu_ready}, 32'd0);
    tick();
    chk_port("waw_load_write", 1'b1, 5'd7, 32'h70);
    lsu_valid = 1'b0;
    #1;
    chk("waw_cleared", {31'd0, query_busy}, 32'd0);
    chk("waw_exu_go", {31'd0, exu_ready}, 32'd1);
    tick();
    chk_port("waw_exu_write", 1'b1, 5'd7, 32'h77);
    idle();

    // Clear and set of x9 on the same edge: set wins
    ld_issue = 1'b1; ld_rd = 5'd9;
    tick();
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    tick();
    idle();
    query_rs = 5'd9;
    #1;
    chk("setwins_busy", {31'd0, query_busy}, 32'd1);
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h98;
    tick();
    idle();
    #1;
    chk("setwins_cleared", {31'd0, query_busy}, 32'd0);
    tick();

    // Forwarding of an in-flight write of x10
    query_rs = 5'd10;
    #1;
    chk("fwd_idle_hit", {31'd0, fwd_hit}, 32'd0);
    exu_valid = 1'b1; exu_rd = 5'd10; exu_data = 32'hA5A5A5A5;
    tick();
    idle();
`ifdef YSYX_25060170_WBU_FWD_EN
    chk("fwd_hit", {31'd0, fwd_hit}, 32'd1);
    chk("fwd_data", fwd_data, 32'hA5A5A5A5);
`else
    chk("fwd_hit", {31'd0, fwd_hit}, 32'd0);
    chk("fwd_data", fwd_data, 32'd0);
`endif
    tick();
    chk("fwd_after_hit", {31'd0, fwd_hit}, 32'd0);
    chk("rf_x10", rf[10], 32'hA5A5A5A5);

    // Reset on an edge that carries a transfer and a pending load
    ld_issue = 1'b1; ld_rd = 5'd13;
    tick();
    ld_issue = 1'b0;
    query_rs = 5'd13;
    #1;
    chk("rst_pre_busy", {31'd0, query_busy}, 32'd1);
    rst = 1'b1;
    exu_valid = 1'b1; exu_rd = 5'd12; exu_data = 32'h1212;
    tick();
    chk_port("rst_mid", 1'b0, 5'd0, 32'd0);
    chk("rst_busy", {31'd0, query_busy}, 32'd0);
    rst = 1'b0;
    idle();
    tick();
    chk("rst_dropped", {31'd0, GPR_we}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
